// File: rtl/color_centroid.sv
// color_centroid: per-frame colour match accumulator with bounding box and
// serial restoring-divider centroid of matched pixel coordinates.
module color_centroid #(
  parameter int         X_WIDTH          = 10,
  parameter int         Y_WIDTH          = 10,
  parameter int         SUM_WIDTH        = 30,
  parameter int         CNT_WIDTH        = 21,
  parameter logic [4:0] MIN_MAIN_COLOR   = 5'd7,
  parameter logic [4:0] COLOR_DIFFERENCE = 5'd4,
  parameter int         MIN_COUNT        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [17:0]          pixel,
  input  logic                 pixel_valid,
  input  logic [X_WIDTH-1:0]   x,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic [1:0]           color_select,
  output logic [X_WIDTH-1:0]   x_center,
  output logic [Y_WIDTH-1:0]   y_center,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [X_WIDTH-1:0]   x_min,
  output logic [X_WIDTH-1:0]   x_max,
  output logic [Y_WIDTH-1:0]   y_min,
  output logic [Y_WIDTH-1:0]   y_max,
  output logic                 found,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 overrun
);
  localparam int IW = $clog2(SUM_WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t state, nextState;

  logic [4:0] red, green, blue, mainC, other1, other2;
  logic match, boundary, snapTake, primed, enough, snapFound, lastIter;
  logic [SUM_WIDTH-1:0] xSum, ySum, qx, qy, rx, ry, divisor;
  logic [SUM_WIDTH:0] trialX, trialY, diffX, diffY;
  logic [CNT_WIDTH-1:0] cnt, snapCnt;
  logic [X_WIDTH-1:0] xMinA, xMaxA, snapXMin, snapXMax;
  logic [Y_WIDTH-1:0] yMinA, yMaxA, snapYMin, snapYMax;
  logic [IW-1:0] iter;

  always_comb begin
    red      = 5'(pixel[17:12] >> 1);
    green    = 5'(pixel[11:6] >> 1);
    blue     = 5'(pixel[5:0] >> 1);
    mainC    = color_select == 2'd0 ? red : color_select == 2'd1 ? green : blue;
    other1   = color_select == 2'd0 ? green : color_select == 2'd1 ? blue : red;
    other2   = color_select == 2'd0 ? blue : color_select == 2'd1 ? red : green;
    match    = pixel_valid && color_select != 2'd3 && mainC > MIN_MAIN_COLOR &&
               {1'b0, mainC} > {1'b0, other1} + {1'b0, COLOR_DIFFERENCE} &&
               {1'b0, mainC} > {1'b0, other2} + {1'b0, COLOR_DIFFERENCE};
    boundary = pixel_valid && x == '0 && y == '0;
    busy     = state == DIVIDE;
    snapTake = boundary && primed && state == IDLE;
    enough   = cnt >= CNT_WIDTH'(MIN_COUNT);
    snapFound = snapCnt >= CNT_WIDTH'(MIN_COUNT);
    lastIter = iter == IW'(SUM_WIDTH - 1);
    divisor  = SUM_WIDTH'(snapCnt);
    trialX   = {rx, qx[SUM_WIDTH-1]};
    trialY   = {ry, qy[SUM_WIDTH-1]};
    diffX    = trialX - {1'b0, divisor};
    diffY    = trialY - {1'b0, divisor};
    nextState = state == IDLE ? (snapTake ? (enough ? DIVIDE : DONE) : IDLE) :
                state == DIVIDE ? (lastIter ? DONE : DIVIDE) : IDLE;
  end

  // The boundary pixel sits at (0,0), so a matching one reseeds sums at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xSum  <= '0;
      ySum  <= '0;
      cnt   <= '0;
      xMinA <= '1;
      xMaxA <= '0;
      yMinA <= '1;
      yMaxA <= '0;
    end else if (boundary) begin
      xSum  <= '0;
      ySum  <= '0;
      cnt   <= match ? CNT_WIDTH'(1) : '0;
      xMinA <= match ? '0 : '1;
      xMaxA <= '0;
      yMinA <= match ? '0 : '1;
      yMaxA <= '0;
    end else if (match) begin
      xSum  <= xSum + SUM_WIDTH'(x);
      ySum  <= ySum + SUM_WIDTH'(y);
      cnt   <= &cnt ? cnt : cnt + CNT_WIDTH'(1);
      xMinA <= x < xMinA ? x : xMinA;
      xMaxA <= x > xMaxA ? x : xMaxA;
      yMinA <= y < yMinA ? y : yMinA;
      yMaxA <= y > yMaxA ? y : yMaxA;
    end
  end

  // Dividends load straight into the quotient registers and shift out MSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      primed   <= 1'b0;
      qx       <= '0;
      qy       <= '0;
      rx       <= '0;
      ry       <= '0;
      iter     <= '0;
      snapCnt  <= '0;
      snapXMin <= '1;
      snapXMax <= '0;
      snapYMin <= '1;
      snapYMax <= '0;
    end else begin
      state  <= nextState;
      primed <= primed || boundary;
      if (snapTake) begin
        qx       <= xSum;
        qy       <= ySum;
        rx       <= '0;
        ry       <= '0;
        iter     <= '0;
        snapCnt  <= cnt;
        snapXMin <= xMinA;
        snapXMax <= xMaxA;
        snapYMin <= yMinA;
        snapYMax <= yMaxA;
      end else if (state == DIVIDE) begin
        qx   <= {qx[SUM_WIDTH-2:0], ~diffX[SUM_WIDTH]};
        qy   <= {qy[SUM_WIDTH-2:0], ~diffY[SUM_WIDTH]};
        rx   <= diffX[SUM_WIDTH] ? trialX[SUM_WIDTH-1:0] : diffX[SUM_WIDTH-1:0];
        ry   <= diffY[SUM_WIDTH] ? trialY[SUM_WIDTH-1:0] : diffY[SUM_WIDTH-1:0];
        iter <= iter + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_center     <= '0;
      y_center     <= '0;
      match_count  <= '0;
      x_min        <= '1;
      x_max        <= '0;
      y_min        <= '1;
      y_max        <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= state == DONE;
      overrun      <= boundary && busy;
      if (state == DONE) begin
        match_count <= snapCnt;
        x_min       <= snapXMin;
        x_max       <= snapXMax;
        y_min       <= snapYMin;
        y_max       <= snapYMax;
        found       <= snapFound;
        x_center    <= snapFound ? qx[X_WIDTH-1:0] : x_center;
        y_center    <= snapFound ? qy[Y_WIDTH-1:0] : y_center;
      end
    end
  end
endmodule

// File: tb/tb_color_centroid.sv
// tb_color_centroid: directed frames with hand-computed centroid, bbox and timing.
module tb_color_centroid;
  localparam logic [17:0] RED  = {6'd63, 12'd0};
  localparam logic [17:0] BLUE = 18'd63;
  localparam logic [17:0] NEAR = {6'd40, 6'd36, 6'd0};

  logic clk = 1'b0, reset = 1'b0, pixel_valid = 1'b0, found, result_valid, busy, overrun;
  logic [17:0] pixel = '0;
  logic [9:0] x = '0, y = '0, x_center, y_center, x_min, x_max, y_min, y_max;
  logic [1:0] color_select = 2'd0;
  logic [20:0] match_count;
  int total = 0, bad = 0, rvCnt = 0, ovCnt = 0, n, rv0, ov0;

  color_centroid dut (
    .clk(clk), .reset(reset), .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .color_select(color_select), .x_center(x_center), .y_center(y_center),
    .match_count(match_count), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .found(found), .result_valid(result_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (result_valid) rvCnt <= rvCnt + 1;
    if (overrun) ovCnt <= ovCnt + 1;
  end

  task check(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task put(input int px, input int py, input logic [17:0] pv, input logic v);
    x = 10'(px);
    y = 10'(py);
    pixel = pv;
    pixel_valid = v;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task block(input int x0, input int y0, input int w, input int h, input logic [17:0] pv);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) put(x0 + i, y0 + j, pv, 1'b1);
  endtask

  task idle(input int k);
    for (int i = 0; i < k; i++) put(1, 1, 18'd0, 1'b0);
  endtask

  task waitResult(output int cyc);
    cyc = 0;
    while (!result_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("result_seen", result_valid, 1);
  endtask

  task checkBox(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_xmin"}, x_min, a);
    check({tag, "_xmax"}, x_max, b);
    check({tag, "_ymin"}, y_min, c);
    check({tag, "_ymax"}, y_max, d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_xc", x_center, 0);
    check("rst_cnt", match_count, 0);
    checkBox("rst", 1023, 0, 1023, 0);
    check("rst_found", found, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    reset = 1'b1;
    idle(2);
    put(0, 0, 18'd0, 1'b1);
    idle(3);
    check("prime_no_rv", rvCnt, 0);

    block(100, 50, 4, 4, RED);
    put(110, 60, RED, 1'b0);
    put(120, 70, NEAR, 1'b1);
    put(0, 0, 18'd0, 1'b1);
    check("busy_on", busy, 1);
    waitResult(n);
    check("lat_found", n + 1, 32);
    check("f1_xc", x_center, 101);
    check("f1_yc", y_center, 51);
    check("f1_cnt", match_count, 16);
    checkBox("f1", 100, 103, 50, 53);
    check("f1_found", found, 1);
    check("f1_busy", busy, 0);

    block(100, 50, 3, 3, RED);
    put(0, 0, 18'd0, 1'b1);
    waitResult(n);
    check("lat_small", n + 1, 2);
    check("f2_cnt", match_count, 9);
    check("f2_found", found, 0);
    check("f2_xc", x_center, 101);
    check("f2_yc", y_center, 51);
    checkBox("f2", 100, 102, 50, 52);

    color_select = 2'd3;
    block(100, 50, 4, 4, RED);
    color_select = 2'd2;
    block(200, 10, 16, 1, BLUE);
    put(0, 0, 18'd0, 1'b1);
    waitResult(n);
    check("f3_cnt", match_count, 16);
    check("f3_xc", x_center, 207);
    check("f3_yc", y_center, 10);
    checkBox("f3", 200, 215, 10, 10);

    color_select = 2'd3;
    block(100, 50, 2, 2, RED);
    put(0, 0, 18'd0, 1'b1);
    waitResult(n);
    check("f4_cnt", match_count, 0);
    check("f4_found", found, 0);
    checkBox("f4", 1023, 0, 1023, 0);
    check("f4_xc_hold", x_center, 207);

    color_select = 2'd0;
    block(300, 400, 4, 4, RED);
    idle(2);
    rv0 = rvCnt;
    ov0 = ovCnt;
    put(0, 0, 18'd0, 1'b1);
    put(500, 500, RED, 1'b1);
    put(501, 500, RED, 1'b1);
    idle(7);
    check("ov_quiet", overrun, 0);
    put(0, 0, 18'd0, 1'b1);
    check("ov_pulse", overrun, 1);
    block(100, 50, 3, 3, RED);
    check("ov_once", overrun, 0);
    waitResult(n);
    check("f5_xc", x_center, 301);
    check("f5_yc", y_center, 401);
    check("f5_cnt", match_count, 16);
    idle(2);
    put(0, 0, 18'd0, 1'b1);
    waitResult(n);
    check("f6_cnt", match_count, 9);
    check("f6_xmin", x_min, 100);
    idle(3);
    check("ov_count", ovCnt - ov0, 1);
    check("rv_count", rvCnt - rv0, 2);

    block(300, 400, 4, 4, RED);
    put(0, 0, 18'd0, 1'b1);
    idle(5);
    check("div_busy", busy, 1);
    rv0 = rvCnt;
    reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_xc", x_center, 0);
    check("ar_cnt", match_count, 0);
    check("ar_found", found, 0);
    check("ar_xmin", x_min, 1023);
    #3;
    reset = 1'b1;
    idle(40);
    check("ar_no_rv", rvCnt - rv0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
